// File: rtl/sr_arb_pkg.sv
// Shared types for the SR flag arbiter:
// FSM states and set/clear command codes.
package sr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      APPLY   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   localparam logic [1:0] CMD_HOLD = 2'b00;
   localparam logic [1:0] CMD_CLR  = 2'b01;
   localparam logic [1:0] CMD_SET  = 2'b10;
   localparam logic [1:0] CMD_BAD  = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set
// req bit at or above ptr, with wrap-around.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic [PW-1:0]   win_idx,
   output logic            any
);

   logic [NREQ-1:0] rot;
   logic [PW-1:0]   off;
   logic [PW:0]     sum;

   // rot[k] is req[(ptr + k) mod NREQ]
   assign rot = NREQ'({req, req} >> ptr);
   assign any = |req;

   always_comb begin
      off = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) off = PW'(k);
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      win_idx = sum[PW-1:0];
      win = any ? (NREQ'(1) << win_idx) : '0;
   end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Bank of SR status flags shared by several requesters;
// one round-robin granted set/clear command per 3 cycles.
module sr_flag_arbiter
   import sr_arb_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int NFLAG = 8,
   parameter int IDXW  = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      s,
   input  logic [NREQ-1:0]      r,
   input  logic [NREQ*IDXW-1:0] idx,
   input  logic                 err_clr,
   output logic [NREQ-1:0]      gnt,
   output logic [NFLAG-1:0]     q,
   output logic [NFLAG-1:0]     qb,
   output logic                 err,
   output logic                 busy
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t           state;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    win_q;
   logic [PW-1:0]    win_idx;
   logic [NREQ-1:0]  win;
   logic             any;
   logic [1:0]       cmd_q;
   logic [IDXW-1:0]  tgt_q;
   logic [1:0]       sel_cmd;
   logic [IDXW-1:0]  sel_idx;
   logic             in_range;
   logic             bad;
   logic [NFLAG-1:0] q_nxt;

   rr_arbiter #(
      .NREQ(NREQ),
      .PW  (PW)
   ) u_rr (
      .req    (req),
      .ptr    (ptr),
      .win    (win),
      .win_idx(win_idx),
      .any    (any)
   );

   assign qb = ~q;

   always_comb begin
      sel_cmd = CMD_HOLD;
      sel_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (win[k]) begin
            sel_cmd = {s[k], r[k]};
            sel_idx = idx[k*IDXW +: IDXW];
         end
      end
   end

   assign in_range = {1'b0, tgt_q} < (IDXW+1)'(NFLAG);
   assign bad      = (cmd_q == CMD_BAD) || !in_range;

   // S=R=1 and out-of-range targets leave every flag untouched
   always_comb begin
      q_nxt = q;
      for (int i = 0; i < NFLAG; i++) begin
         if (in_range && tgt_q == IDXW'(i)) begin
            case (cmd_q)
               CMD_CLR: q_nxt[i] = 1'b0;
               CMD_SET: q_nxt[i] = 1'b1;
               default: q_nxt[i] = q[i];
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         gnt   <= '0;
         busy  <= 1'b0;
         ptr   <= '0;
         win_q <= '0;
         cmd_q <= CMD_HOLD;
         tgt_q <= '0;
         q     <= '0;
         err   <= 1'b0;
      end else begin
         if (state == APPLY && bad) err <= 1'b1;
         else if (err_clr)          err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any) begin
                  win_q <= win_idx;
                  cmd_q <= sel_cmd;
                  tgt_q <= sel_idx;
                  gnt   <= win;
                  busy  <= 1'b1;
                  state <= APPLY;
               end
            end
            APPLY: begin
               gnt   <= '0;
               q     <= q_nxt;
               ptr   <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
               state <= RELEASE;
            end
            RELEASE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               gnt   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: vector table through a
// grant scoreboard plus hand-written corner sequences.
module tb_sr_flag_arbiter;

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  s;
      logic [3:0]  r;
      logic [11:0] idx;
      logic [3:0]  gnt;
      logic [7:0]  q;
      logic        err;
      int          gap;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0, s = '0, r = '0;
   logic [11:0] idx = '0;
   logic        err_clr = 1'b0;
   logic [3:0]  gnt;
   logic [7:0]  q, qb;
   logic        err, busy;

   logic [3:0]  req6 = '0, s6 = '0, r6 = '0;
   logic [11:0] idx6 = '0;
   logic        err_clr6 = 1'b0;
   logic [3:0]  gnt6;
   logic [5:0]  q6, qb6;
   logic        err6, busy6;

   int   ncheck = 0;
   int   nfail = 0;
   int   cyc = 0;
   int   last_g = -1;
   bit   chk_pend = 0;
   bit   done_f = 0;
   vec_t cur;
   vec_t sb[$];
   vec_t tv[16];

   sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDXW(3)) dut (
      .clk(clk), .rst(rst), .req(req), .s(s), .r(r),
      .idx(idx), .err_clr(err_clr), .gnt(gnt), .q(q),
      .qb(qb), .err(err), .busy(busy)
   );

   sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3)) dut6 (
      .clk(clk), .rst(rst), .req(req6), .s(s6), .r(r6),
      .idx(idx6), .err_clr(err_clr6), .gnt(gnt6), .q(q6),
      .qb(qb6), .err(err6), .busy(busy6)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ncheck++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [11:0] mk(input logic [2:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   function automatic vec_t v(input logic [3:0] rq, ss, rr,
                              input logic [11:0] ix,
                              input logic [3:0] g,
                              input logic [7:0] qq,
                              input logic e, input int gp);
      vec_t t;
      t.req = rq; t.s = ss; t.r = rr; t.idx = ix;
      t.gnt = g; t.q = qq; t.err = e; t.gap = gp;
      return t;
   endfunction

   // one clock; grant monitor and scoreboard compare at negedge
   task automatic tick();
      logic [7:0] eqb;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (chk_pend) begin
         eqb = ~cur.q;
         chk("q", 32'(q), 32'(cur.q));
         chk("qb", 32'(qb), 32'(eqb));
         chk("err", 32'(err), 32'(cur.err));
         chk_pend = 0;
         done_f = 1;
      end
      if (|gnt) begin
         req = req & ~gnt;
         if (sb.size() == 0) begin
            chk("spurious_gnt", 32'(gnt), 32'(0));
         end else begin
            cur = sb.pop_front();
            chk("gnt", 32'(gnt), 32'(cur.gnt));
            chk_pend = 1;
            if (cur.gap != 0) chk("gnt_gap", 32'(cyc - last_g), 32'(cur.gap));
         end
         last_g = cyc;
      end
   endtask

   task automatic run_one(input vec_t t);
      int n;
      req = req | t.req;
      s = t.s; r = t.r; idx = t.idx;
      sb.push_back(t);
      done_f = 0;
      n = 0;
      while (!done_f && n < 20) begin
         tick();
         n++;
      end
      chk("grant_timeout", 32'(done_f), 32'(1));
      tick();
      chk("busy_idle", 32'(busy), 32'(0));
   endtask

   initial begin
      tv[0]  = v(4'hF, 4'hF, 4'h0, mk(3'd0,3'd1,3'd2,3'd3), 4'h1, 8'h01, 1'b0, 0);
      tv[1]  = v(4'h0, 4'hF, 4'h0, mk(3'd0,3'd1,3'd2,3'd3), 4'h2, 8'h03, 1'b0, 3);
      tv[2]  = v(4'h0, 4'hF, 4'h0, mk(3'd0,3'd1,3'd2,3'd3), 4'h4, 8'h07, 1'b0, 3);
      tv[3]  = v(4'h0, 4'hF, 4'h0, mk(3'd0,3'd1,3'd2,3'd3), 4'h8, 8'h0F, 1'b0, 3);
      tv[4]  = v(4'h4, 4'h4, 4'h0, mk(3'd0,3'd0,3'd5,3'd0), 4'h4, 8'h2F, 1'b0, 3);
      tv[5]  = v(4'h8, 4'h8, 4'h0, mk(3'd0,3'd0,3'd0,3'd7), 4'h8, 8'hAF, 1'b0, 3);
      tv[6]  = v(4'h9, 4'h0, 4'h9, mk(3'd5,3'd0,3'd0,3'd7), 4'h1, 8'h8F, 1'b0, 3);
      tv[7]  = v(4'h0, 4'h0, 4'h9, mk(3'd5,3'd0,3'd0,3'd7), 4'h8, 8'h0F, 1'b0, 3);
      tv[8]  = v(4'h2, 4'h2, 4'h2, mk(3'd0,3'd2,3'd0,3'd0), 4'h2, 8'h0F, 1'b1, 3);
      tv[9]  = v(4'h1, 4'h0, 4'h0, mk(3'd0,3'd0,3'd0,3'd0), 4'h1, 8'h0F, 1'b1, 3);
      tv[10] = v(4'h2, 4'h0, 4'h2, mk(3'd0,3'd0,3'd0,3'd0), 4'h2, 8'h0E, 1'b1, 3);
      tv[11] = v(4'hF, 4'hF, 4'h0, mk(3'd4,3'd5,3'd6,3'd7), 4'h4, 8'h4E, 1'b1, 3);
      tv[12] = v(4'h0, 4'hF, 4'h0, mk(3'd4,3'd5,3'd6,3'd7), 4'h8, 8'hCE, 1'b1, 3);
      tv[13] = v(4'h0, 4'hF, 4'h0, mk(3'd4,3'd5,3'd6,3'd7), 4'h1, 8'hDE, 1'b1, 3);
      tv[14] = v(4'h0, 4'hF, 4'h0, mk(3'd4,3'd5,3'd6,3'd7), 4'h2, 8'hFE, 1'b1, 3);
      tv[15] = v(4'h1, 4'h1, 4'h0, mk(3'd0,3'd0,3'd0,3'd0), 4'h1, 8'hFF, 1'b1, 3);

      #1 rst = 1'b0;
      #1;
      chk("rst_q", 32'(q), 32'(8'h00));
      chk("rst_qb", 32'(qb), 32'(8'hFF));
      chk("rst_gnt", 32'(gnt), 32'(0));
      chk("rst_err", 32'(err), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_q6", 32'(q6), 32'(0));
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 16; i++) run_one(tv[i]);

      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("err_clr", 32'(err), 32'(0));
      chk("q_after_clr", 32'(q), 32'(8'hFF));

      // bad command sets err, then reset lands during the next APPLY
      run_one(v(4'h1, 4'h1, 4'h1, mk(3'd0,3'd0,3'd0,3'd0), 4'h1, 8'hFF, 1'b1, 0));
      req = req | 4'h2;
      s = 4'h0; r = 4'h2; idx = mk(3'd0,3'd3,3'd0,3'd0);
      sb.push_back(v(4'h2, 4'h0, 4'h2, idx, 4'h2, 8'hF7, 1'b1, 0));
      tick();
      chk("pre_rst_err", 32'(err), 32'(1));
      chk("pre_rst_busy", 32'(busy), 32'(1));
      rst = 1'b0;
      #1;
      chk("arst_q", 32'(q), 32'(8'h00));
      chk("arst_qb", 32'(qb), 32'(8'hFF));
      chk("arst_err", 32'(err), 32'(0));
      chk("arst_gnt", 32'(gnt), 32'(0));
      chk("arst_busy", 32'(busy), 32'(0));
      sb.delete();
      chk_pend = 0;
      req = '0; s = '0; r = '0; idx = '0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         run_one(v((k == 0) ? 4'hF : 4'h0, 4'h0, 4'h0, 12'h000,
                   4'(1 << k), 8'h00, 1'b0, (k == 0) ? 0 : 3));
      end

      // out-of-range target on the 6-flag bank, with err_clr on the same edge
      req6 = 4'h1; s6 = 4'h1; r6 = 4'h0; idx6 = mk(3'd7,3'd0,3'd0,3'd0);
      tick();
      chk("gnt6", 32'(gnt6), 32'(4'h1));
      chk("busy6", 32'(busy6), 32'(1));
      req6 = 4'h0;
      err_clr6 = 1'b1;
      tick();
      err_clr6 = 1'b0;
      chk("q6_oor", 32'(q6), 32'(0));
      chk("err6_setwins", 32'(err6), 32'(1));
      tick();
      chk("err6_sticky", 32'(err6), 32'(1));
      chk("busy6_idle", 32'(busy6), 32'(0));
      err_clr6 = 1'b1;
      tick();
      err_clr6 = 1'b0;
      chk("err6_clr", 32'(err6), 32'(0));
      req6 = 4'h1; s6 = 4'h1; idx6 = mk(3'd5,3'd0,3'd0,3'd0);
      tick();
      req6 = 4'h0;
      chk("gnt6_b", 32'(gnt6), 32'(4'h1));
      tick();
      chk("q6_set5", 32'(q6), 32'(6'h20));
      chk("qb6_set5", 32'(qb6), 32'(6'h1F));
      chk("err6_ok", 32'(err6), 32'(0));

      chk("sb_drained", 32'(sb.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures",
               ncheck, nfail);
      $finish;
   end

endmodule
